// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: controller state encoding,
// default operand width and the step-counter width helper.
package mult_pkg;

  // Default multiplier operand width (accumulator is 2*WIDTH+1 bits).
  localparam int WIDTH_DEFAULT = 16;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHK   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Step counter width; kept at least 1 bit so degenerate widths still elaborate.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mult_ctrl.sv
// Shift-add multiplier control unit. Sequences one multiply of WIDTH
// multiplier bits by issuing Load, then per bit an optional Ad followed by
// Sh, and finally a one-cycle Done pulse. Outputs are combinational from
// state, St and M, and are all forced low while Rst_n is low.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic St,
  input  logic M,
  output logic Load,
  output logic Sh,
  output logic Ad,
  output logic Busy,
  output logic Done
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Ungated strobes straight from the state decode.
  logic load_raw, sh_raw, ad_raw, done_raw;

  // State and step-counter registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter update and strobe decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_raw = 1'b0;
    sh_raw   = 1'b0;
    ad_raw   = 1'b0;
    done_raw = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Load is Mealy on St so the accumulator loads in the request cycle.
        load_raw = St;
        if (St) begin
          state_d = CHK;
          cnt_d   = '0;
        end
      end

      CHK: begin
        if (M) begin
          // Add first; the shift for this bit happens in SHIFT.
          ad_raw  = 1'b1;
          state_d = SHIFT;
        end else begin
          // Zero bit: shift directly, no add needed.
          sh_raw = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      SHIFT: begin
        sh_raw = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = CHK;
        end
      end

      DONE: begin
        done_raw = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset gates every output combinationally, independent of the stored state.
  assign Load = Rst_n & load_raw;
  assign Sh   = Rst_n & sh_raw;
  assign Ad   = Rst_n & ad_raw;
  assign Done = Rst_n & done_raw;
  assign Busy = Rst_n & (state_q != IDLE);

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: a behavioural 33-bit accumulator and multiplicand
// register sit around the controller; expectations (product, Done cycle,
// Ad/Sh counts) come from plain arithmetic on the operands.
module tb_mult_ctrl;
  import mult_pkg::*;

  localparam int W = 16;

  logic clk;
  logic Rst_n, St, M;
  logic Load, Sh, Ad, Busy, Done;

  logic [W-1:0]   mplier, mcand;
  logic [2*W:0]   acc;

  int n_cmp, n_err;
  int load_seen, done_seen, abort_cnt;

  mult_ctrl #(.WIDTH(W)) dut (
    .Clk  (clk),
    .Rst_n(Rst_n),
    .St   (St),
    .M    (M),
    .Load (Load),
    .Sh   (Sh),
    .Ad   (Ad),
    .Busy (Busy),
    .Done (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural accumulator driven by the controller strobes.
  always @(posedge clk) begin
    if (Load)    acc <= {{(W+1){1'b0}}, mplier};
    else if (Ad) acc[2*W:W] <= acc[2*W:W] + {1'b0, mcand};
    else if (Sh) acc <= acc >> 1;
  end
  assign M = acc[0];

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
    int             done_c;
    int             n_ad;
    int             n_sh;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, sample 1 time unit later.
  task automatic tick(input logic st, input logic rst);
    int s;
    @(negedge clk);
    St    = st;
    Rst_n = rst;
    #1;
    s = int'(Load) + int'(Sh) + int'(Ad);
    chk("exclusive", 64'(s <= 1), 64'd1);
    if (Load) load_seen++;
    if (Done) done_seen++;
  endtask

  function automatic int popcount(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(v[i]);
    return n;
  endfunction

  // Run one multiply from its Load cycle; optionally re-pulse St mid-run
  // or hold St high so a second multiply starts right after Done.
  task automatic run_mult(input string name, input vec_t v, input bit repulse, input bit hold);
    int done_c, nad, nsh, loads;
    bit busy_ok;
    logic [2*W-1:0] prod;
    mplier = v.a;
    mcand  = v.b;
    tick(1'b1, 1'b1);
    chk({name, ".load_c0"}, 64'(Load), 64'd1);
    chk({name, ".busy_c0"}, 64'(Busy), 64'd0);
    done_c = -1; nad = 0; nsh = 0; loads = 0; busy_ok = 1'b1; prod = '0;
    for (int c = 1; c <= 60 && done_c < 0; c++) begin
      tick(hold | (repulse && (c == 5 || c == 10)), 1'b1);
      if (Load)  loads++;
      if (Ad)    nad++;
      if (Sh)    nsh++;
      if (!Busy) busy_ok = 1'b0;
      if (Done) begin
        done_c = c;
        prod   = acc[2*W-1:0];
      end
    end
    chk({name, ".done_cycle"}, 64'(done_c), 64'(v.done_c));
    chk({name, ".ad_count"},   64'(nad),    64'(v.n_ad));
    chk({name, ".sh_count"},   64'(nsh),    64'(v.n_sh));
    chk({name, ".product"},    64'(prod),   64'(v.prod));
    chk({name, ".busy_span"},  64'(busy_ok), 64'd1);
    chk({name, ".no_reload"},  64'(loads),  64'd0);
    tick(hold, 1'b1);
    chk({name, ".busy_after"}, 64'(Busy), 64'd0);
    chk({name, ".done_after"}, 64'(Done), 64'd0);
    if (hold) begin
      chk({name, ".reload"}, 64'(Load), 64'd1);
      done_c = -1;
      for (int c = 1; c <= 60 && done_c < 0; c++) begin
        tick(1'b0, 1'b1);
        if (Done) begin
          done_c = c;
          prod   = acc[2*W-1:0];
        end
      end
      chk({name, ".rerun_done"}, 64'(done_c), 64'(v.done_c));
      chk({name, ".rerun_prod"}, 64'(prod),   64'(v.prod));
      tick(1'b0, 1'b1);
    end
  endtask

  vec_t tbl [6];
  vec_t rv;

  initial begin
    n_cmp = 0; n_err = 0; load_seen = 0; done_seen = 0; abort_cnt = 0;
    St = 1'b0; Rst_n = 1'b0; mplier = '0; mcand = '0; acc = '0;

    tbl[0] = '{16'd7,      16'd200,    32'd1400,        20, 3,  16};
    tbl[1] = '{16'd0,      16'd200,    32'd0,           17, 0,  16};
    tbl[2] = '{16'hFFFF,   16'hFFFF,   32'hFFFE0001,    33, 16, 16};
    tbl[3] = '{16'd1,      16'd1,      32'd1,           18, 1,  16};
    tbl[4] = '{16'h8000,   16'd3,      32'h00018000,    18, 1,  16};
    tbl[5] = '{16'h00F0,   16'h0100,   32'h0000F000,    21, 4,  16};

    // Reset: outputs gated low even with St high.
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("reset_outs", 64'({Load, Sh, Ad, Busy, Done}), 64'd0);
    tick(1'b0, 1'b1);
    chk("reset_idle_busy", 64'(Busy), 64'd0);
    chk("reset_idle_load", 64'(Load), 64'd0);

    // St high during reset is ignored; accepted in the first released cycle.
    tick(1'b1, 1'b0);
    chk("st_in_reset", 64'(Load), 64'd0);
    run_mult("rel_7x200", tbl[0], 1'b0, 1'b0);

    // Table vectors.
    for (int i = 0; i < 6; i++) run_mult($sformatf("vec%0d", i), tbl[i], 1'b0, 1'b0);

    // St re-pulsed mid-multiply, then St held through DONE.
    run_mult("repulse", tbl[0], 1'b1, 1'b0);
    run_mult("hold", tbl[0], 1'b0, 1'b1);

    // Reset in cycle 8 of a multiply.
    mplier = 16'd7; mcand = 16'd200;
    tick(1'b1, 1'b1);
    for (int c = 1; c < 8; c++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    abort_cnt++;
    chk("midrst_outs", 64'({Load, Sh, Ad, Busy, Done}), 64'd0);
    tick(1'b0, 1'b1);
    chk("midrst_busy", 64'(Busy), 64'd0);
    chk("midrst_load", 64'(Load), 64'd0);
    run_mult("after_rst", tbl[0], 1'b0, 1'b0);

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 20; i++) begin
      rv.a      = W'($urandom);
      rv.b      = W'($urandom);
      rv.prod   = rv.a * rv.b;
      rv.n_ad   = popcount(rv.a);
      rv.n_sh   = W;
      rv.done_c = W + rv.n_ad + 1;
      run_mult($sformatf("rnd%0d", i), rv, 1'b0, 1'b0);
    end

    chk("done_per_load", 64'(done_seen), 64'(load_seen - abort_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_ctrl.md
# mult_ctrl

Control unit for the shift-add multiplier datapath. It drives the accumulator's Load, Sh and Ad strobes from a start request and the accumulator LSB, sequencing one multiply of WIDTH multiplier bits. It sits beside the 2·WIDTH+1-bit accumulator in the multiplier, between the CPU's execute stage and the datapath. With the default WIDTH=16 the accumulator is 33 bits wide.

## Interface
- WIDTH, 16, multiplier operand width; number of shift steps per multiply
- Clk  in  1  clock; all state updates on rising edge
- Rst_n  in  1  reset, synchronous, active-low
- St  in  1  start request; sampled only in IDLE
- M  in  1  accumulator bit 0 (current multiplier LSB)
- Load  out  1  accumulator parallel load
- Sh  out  1  accumulator right shift
- Ad  out  1  accumulator add of multiplicand into upper half
- Busy  out  1  high whenever state ≠ IDLE
- Done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CHK, SHIFT, DONE. Step counter cnt is $clog2(WIDTH) bits wide and counts 0..WIDTH-1.
- **IDLE**
  - Load = St (Mealy).
  - If St = 1: next state CHK, cnt ← 0.
  - Otherwise: stay in IDLE.
- **CHK**
  - If M = 1: Ad = 1, next state SHIFT.
  - If M = 0: Sh = 1. If cnt = WIDTH-1, next state DONE; otherwise cnt ← cnt+1 and stay in CHK.
- **SHIFT**
  - Sh = 1.
  - If cnt = WIDTH-1: next state DONE. Otherwise cnt ← cnt+1, next state CHK.
- **DONE**
  - Done = 1, next state IDLE.
- At most one of Load, Sh and Ad is high in any cycle.
- Outputs are combinational from state, St and M. No other outputs are asserted.
- St is ignored outside IDLE. There is no queueing and no abort input.
- If St is held high, a new multiply starts in the IDLE cycle that follows DONE.
- cnt wraps only through the reload in IDLE. It never increments past WIDTH-1.

## Timing
- **Reset**
  - While Rst_n = 0, Load, Sh, Ad, Busy and Done are forced to 0, combinationally gated.
  - At the clock edge: state ← IDLE, cnt ← 0.
  - Reset mid-operation abandons the multiply. Accumulator contents are left undefined for the caller.
- **Latency**, counted from the Load cycle (cycle 0):
  - Done rises in cycle WIDTH + k + 1, where k = number of 1 bits in the multiplier.
  - Minimum is WIDTH+1 (multiplier 0). Maximum is 2·WIDTH+1 (all ones).
- **Busy** is high from cycle 1 through the DONE cycle inclusive. Busy is low in the Load cycle.
- **M** must reflect the accumulator after the previous edge. The accumulator is registered, so no extra stage is needed.
- **St = 1 in the same cycle as reset release** (Rst_n rising at that edge): St is not accepted until the first cycle with Rst_n = 1 in IDLE.

## Structure
- Package mult_pkg holds:
  - state enum (IDLE, CHK, SHIFT, DONE)
  - default WIDTH constant
  - counter width function/constant
- mult_pkg is shared with the multiplier top and its bench.
- No sub-module: the FSM and counter are inline, roughly 150 lines.
- The integration wrapper mult_top (ACC + mult_ctrl + multiplicand register) is a separate block.

## Test plan
All scenarios use WIDTH=16 with the existing ACC and a behavioural multiplicand register.
- **Multiply 7 × 200**, pulse St: Load in cycle 0, 3 Ad and 16 Sh, Done in cycle 20, accumulator low 32 bits = 1400, Busy low the cycle after Done.
- **Multiplier 0 × 200**: 0 Ad, 16 consecutive Sh, Done in cycle 17, product 0.
- **Multiplier 0xFFFF × 0xFFFF**: 16 Ad interleaved with 16 Sh, Done in cycle 33, product 0xFFFE0001.
- **St re-pulsed in cycles 5 and 10 during a multiply**: no Load, sequence and product unchanged. St held high through DONE: Load again in the next IDLE cycle.
- **Rst_n = 0 in cycle 8 of a multiply**: all outputs 0 that cycle, IDLE next cycle, Busy = 0. A subsequent St runs a clean 7 × 200 = 1400.
- **Exclusivity check** over all scenarios: Load + Sh + Ad ≤ 1 every cycle. Done is high exactly one cycle per accepted St.
